// File: rtl/half_layer_sequencer_pkg.sv
// Shared types for the half-precision layer sequencer: half word, FSM states,
// ReLU on a half value and an address-width helper.
package half_nn_pkg;

  typedef logic [15:0] half_t;

  localparam half_t HALF_ZERO = 16'h0000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_FIN   = 3'd4
  } state_t;

  // Any value with the sign bit set (negatives, -0, negative NaN) clamps to +0.
  function automatic half_t half_relu(input half_t x);
    return x[15] ? HALF_ZERO : x;
  endfunction

  // Index width that never collapses to zero bits for a single-entry range.
  function automatic int unsigned addr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/half_layer_sequencer_if.sv
// Operand/result channel between the layer sequencer and the shared half MAC.
interface half_layer_sequencer_if #(
  parameter int unsigned N_IN  = 784,
  parameter int unsigned N_OUT = 50
);
  import half_nn_pkg::*;

  localparam int unsigned XW = addr_w(N_IN);
  localparam int unsigned WW = addr_w(N_IN * N_OUT);
  localparam int unsigned BW = addr_w(N_OUT);

  logic          op_valid;
  logic          op_ready;
  logic          op_first;
  logic          op_last;
  logic [XW-1:0] x_addr;
  logic [WW-1:0] w_addr;
  logic [BW-1:0] b_addr;
  logic          res_valid;
  half_t         res_data;

  modport master (
    output op_valid, op_first, op_last, x_addr, w_addr, b_addr,
    input  op_ready, res_valid, res_data
  );

  modport slave (
    input  op_valid, op_first, op_last, x_addr, w_addr, b_addr,
    output op_ready, res_valid, res_data
  );

endinterface

// File: rtl/half_layer_sequencer_counter.sv
// Saturating up-counter with synchronous clear and terminal-count flag.
module half_seq_counter #(
  parameter int unsigned LAST = 1,
  parameter int unsigned W    = 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         at_last
);

  logic [W-1:0] r_count;
  logic         w_at_last;

  assign w_at_last = (r_count == W'(LAST));

  // Clear wins over increment; increment stops at the terminal count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && !w_at_last) begin
      r_count <= r_count + W'(1);
    end
  end

  assign count   = r_count;
  assign at_last = w_at_last;

endmodule

// File: rtl/half_layer_sequencer.sv
// Walks one fully-connected layer through a shared half-precision MAC:
// streams x/W/b addresses per neuron, then writes the (optionally ReLU'd) result.
module half_layer_sequencer
  import half_nn_pkg::*;
#(
  parameter int unsigned  N_IN    = 784,
  parameter int unsigned  N_OUT   = 50,
  parameter int unsigned  RELU_EN = 1,
  localparam int unsigned BW      = addr_w(N_OUT)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic                    abort,
  output logic                    busy,
  output logic                    done,
  half_layer_sequencer_if.master  mac,
  output logic                    wr_en,
  output logic [BW-1:0]           wr_addr,
  output half_t                   wr_data,
  output logic                    err
);

  localparam int unsigned   XW     = addr_w(N_IN);
  localparam int unsigned   WW     = addr_w(N_IN * N_OUT);
  localparam logic [WW-1:0] W_STEP = WW'(N_OUT);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [XW-1:0] w_i;
  logic [BW-1:0] w_j;
  logic          w_i_last;
  logic          w_j_last;
  logic [WW-1:0] r_w_addr;
  half_t         r_wr_data;
  logic          r_err;

  logic w_start_ok;
  logic w_hs;
  logic w_res_ok;
  logic w_wr_fire;
  logic w_i_clr;
  logic w_j_clr;

  assign w_start_ok = (r_state == ST_IDLE) && start;
  assign w_hs       = (r_state == ST_ISSUE) && mac.op_ready && !abort;
  assign w_res_ok   = (r_state == ST_WAIT) && mac.res_valid && !abort;
  assign w_wr_fire  = (r_state == ST_WRITE) && !abort;
  assign w_i_clr    = w_start_ok || w_wr_fire || abort;
  assign w_j_clr    = w_start_ok || abort;

  half_seq_counter #(.LAST(N_IN - 1), .W(XW)) u_i_cnt (
    .clk     (clk),
    .rstn    (rstn),
    .inc     (w_hs),
    .clr     (w_i_clr),
    .count   (w_i),
    .at_last (w_i_last)
  );

  half_seq_counter #(.LAST(N_OUT - 1), .W(BW)) u_j_cnt (
    .clk     (clk),
    .rstn    (rstn),
    .inc     (w_wr_fire),
    .clr     (w_j_clr),
    .count   (w_j),
    .at_last (w_j_last)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Abort outranks every other event once a pass is running.
  always_comb begin
    w_state_nxt = r_state;
    if (abort && (r_state != ST_IDLE)) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (start) w_state_nxt = ST_ISSUE;
        ST_ISSUE: if (mac.op_ready && w_i_last) w_state_nxt = ST_WAIT;
        ST_WAIT:  if (mac.res_valid) w_state_nxt = ST_WRITE;
        ST_WRITE: w_state_nxt = w_j_last ? ST_FIN : ST_ISSUE;
        ST_FIN:   w_state_nxt = ST_IDLE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy         = 1'b0;
    done         = 1'b0;
    wr_en        = 1'b0;
    mac.op_valid = 1'b0;
    mac.op_first = 1'b0;
    mac.op_last  = 1'b0;
    busy         = (r_state != ST_IDLE);
    case (r_state)
      ST_ISSUE: begin
        mac.op_valid = 1'b1;
        mac.op_first = (w_i == '0);
        mac.op_last  = w_i_last;
      end
      ST_WRITE: wr_en = 1'b1;
      ST_FIN:   done  = 1'b1;
      default:  ;
    endcase
  end

  // Running weight address: +N_OUT per term, restarts at column j per neuron.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_w_addr <= '0;
    end else if (w_start_ok || abort) begin
      r_w_addr <= '0;
    end else if (w_hs && !w_i_last) begin
      r_w_addr <= r_w_addr + W_STEP;
    end else if (w_wr_fire && !w_j_last) begin
      r_w_addr <= WW'(w_j) + WW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_data <= HALF_ZERO;
    end else if (w_res_ok) begin
      r_wr_data <= (RELU_EN != 0) ? half_relu(mac.res_data) : mac.res_data;
    end
  end

  // A stray result strobe is sticky until the next accepted start.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_err <= 1'b0;
    end else if (mac.res_valid && (r_state != ST_WAIT)) begin
      r_err <= 1'b1;
    end else if (w_start_ok) begin
      r_err <= 1'b0;
    end
  end

  assign mac.x_addr = w_i;
  assign mac.w_addr = r_w_addr;
  assign mac.b_addr = w_j;
  assign wr_addr    = w_j;
  assign wr_data    = r_wr_data;
  assign err        = r_err;

endmodule

// File: tb/tb_half_layer_sequencer.sv
// Bench for half_layer_sequencer: MAC responder, table + random passes
// scored against a loop-built reference, plus abort/err/reset/N_IN=1 sequences.
module tb_half_layer_sequencer;
  import half_nn_pkg::*;

  localparam int unsigned NI = 3;
  localparam int unsigned NO = 2;

  typedef struct packed { logic [1:0] x; logic [2:0] w; logic b; logic f; logic l; } hs_t;
  typedef struct packed { logic a; logic [15:0] d; logic [31:0] c; } wr_t;
  typedef struct { int mode; int lat; logic [15:0] r0; logic [15:0] r1; logic [15:0] e0; logic [15:0] e1; } vec_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start = 1'b0, abort = 1'b0;
  logic busy, done, wr_en, err;
  logic wr_addr;
  half_t wr_data;

  logic start_b = 1'b0, abort_b = 1'b0;
  logic busy_b, done_b, wr_en_b, err_b;
  logic wr_addr_b;
  half_t wr_data_b;

  half_layer_sequencer_if #(.N_IN(NI), .N_OUT(NO)) mif ();
  half_layer_sequencer_if #(.N_IN(1), .N_OUT(2))   mif_b ();

  half_layer_sequencer #(.N_IN(NI), .N_OUT(NO), .RELU_EN(1)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort), .busy(busy), .done(done),
    .mac(mif), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .err(err)
  );

  half_layer_sequencer #(.N_IN(1), .N_OUT(2), .RELU_EN(0)) dut_b (
    .clk(clk), .rstn(rstn), .start(start_b), .abort(abort_b), .busy(busy_b), .done(done_b),
    .mac(mif_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b), .err(err_b)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // MAC responder / monitor state (mode: 0 ready, 1 toggle, 2 random, 3 never)
  int    mode = 3;
  int    lat  = 2;
  logic [15:0] res_tab [2];
  logic  rdy = 1'b0;
  int    cnt = 0;
  logic  cur_b = 1'b0;
  bit    inject_rv = 1'b0;
  int    stab_err = 0;
  bit    stall = 1'b0;
  hs_t   snap, cur;
  hs_t   hs_q [$];
  wr_t   wr_q [$];
  int    done_cnt = 0;
  int    done_cyc = 0;

  // Inputs chosen at the falling edge take effect at the next rising edge.
  always @(negedge clk) begin
    if (!rstn) begin
      cnt = 0; rdy = 1'b0; stall = 1'b0;
      mif.op_ready = 1'b0; mif.res_valid = 1'b0; mif.res_data = 16'h0;
    end else begin
      case (mode)
        0: rdy = 1'b1;
        1: rdy = ~rdy;
        2: rdy = 1'($urandom_range(0, 1));
        default: rdy = 1'b0;
      endcase
      mif.op_ready = rdy;
      mif.res_valid = 1'b0;
      mif.res_data = 16'h1234;
      if (abort) cnt = 0;
      else if (cnt != 0) begin
        cnt = cnt - 1;
        if (cnt == 0) begin
          mif.res_valid = 1'b1;
          mif.res_data = res_tab[cur_b];
        end
      end
      if (inject_rv) mif.res_valid = 1'b1;
      cur = {mif.x_addr, mif.w_addr, mif.b_addr, mif.op_first, mif.op_last};
      if (stall && mif.op_valid && (cur != snap)) stab_err = stab_err + 1;
      stall = mif.op_valid && !rdy;
      snap = cur;
      if (mif.op_valid && rdy) begin
        hs_q.push_back(cur);
        if (mif.op_last) begin cnt = lat; cur_b = mif.b_addr; end
      end
      if (wr_en) wr_q.push_back({wr_addr, wr_data, 32'(cyc)});
      if (done) begin done_cnt = done_cnt + 1; done_cyc = cyc; end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot = n_tot + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic logic [15:0] ref_relu(input logic [15:0] v);
    return v[15] ? 16'h0000 : v;
  endfunction

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ctrl"}, 32'({busy, done, mif.op_valid, mif.op_first, mif.op_last, wr_en, err}), 32'h0);
    chk({tag, "_addr"}, 32'({mif.x_addr, mif.w_addr, mif.b_addr, wr_addr}), 32'h0);
    chk({tag, "_wdata"}, 32'(wr_data), 32'h0);
  endtask

  task automatic begin_pass(input int md, input int lt, input logic [15:0] r0, input logic [15:0] r1);
    mode = md; lat = lt; res_tab[0] = r0; res_tab[1] = r1;
    hs_q.delete(); wr_q.delete(); done_cnt = 0; stab_err = 0;
    tick(1); start = 1'b1; tick(1); start = 1'b0;
  endtask

  // Full pass scored against the row-major walk: w = i*NO + j for each j, i.
  task automatic run_pass(input int md, input int lt, input logic [15:0] r0, input logic [15:0] r1,
                          input logic [15:0] e0, input logic [15:0] e1);
    int t;
    hs_t e;
    logic [15:0] ew;
    begin_pass(md, lt, r0, r1);
    chk("op_valid_after_start", 32'(mif.op_valid), 32'h1);
    chk("err_after_start", 32'(err), 32'h0);
    t = 0;
    while (done_cnt == 0 && t < 300) begin tick(1); t++; end
    chk("pass_in_budget", 32'(t < 300), 32'h1);
    tick(2);
    chk("hs_count", 32'(hs_q.size()), 32'(NI * NO));
    for (int j = 0; j < int'(NO); j++) begin
      for (int i = 0; i < int'(NI); i++) begin
        int k = j * int'(NI) + i;
        e.x = 2'(i); e.w = 3'(i * int'(NO) + j); e.b = 1'(j);
        e.f = (i == 0); e.l = (i == int'(NI) - 1);
        chk("hs_entry", (k < hs_q.size()) ? 32'(hs_q[k]) : 32'hFFFF_FFFF, 32'(e));
      end
    end
    chk("wr_count", 32'(wr_q.size()), 32'h2);
    for (int j = 0; j < 2; j++) begin
      ew = (j == 0) ? e0 : e1;
      chk("wr_entry", (j < wr_q.size()) ? 32'({wr_q[j].a, wr_q[j].d}) : 32'hFFFF_FFFF, 32'({1'(j), ew}));
    end
    chk("done_count", 32'(done_cnt), 32'h1);
    chk("done_after_last_write", (wr_q.size() == 2) ? 32'(done_cyc - int'(wr_q[1].c)) : 32'hFFFF_FFFF, 32'h1);
    chk("stall_stable", 32'(stab_err), 32'h0);
    chk("idle_after_pass", 32'(busy), 32'h0);
  endtask

  vec_t tab [4];

  initial begin
    int t;
    logic [15:0] r0, r1;
    tab[0] = '{mode: 0, lat: 2, r0: 16'h3C00, r1: 16'hBC00, e0: 16'h3C00, e1: 16'h0000};
    tab[1] = '{mode: 1, lat: 1, r0: 16'h8000, r1: 16'h7E00, e0: 16'h0000, e1: 16'h7E00};
    tab[2] = '{mode: 2, lat: 3, r0: 16'hFC00, r1: 16'h4000, e0: 16'h0000, e1: 16'h4000};
    tab[3] = '{mode: 1, lat: 5, r0: 16'hFE00, r1: 16'h0001, e0: 16'h0000, e1: 16'h0001};
    mif_b.op_ready = 1'b1; mif_b.res_valid = 1'b0; mif_b.res_data = 16'h0;

    tick(2);
    chk_reset_outs("reset_init");
    rstn = 1'b1;
    tick(2);

    for (int v = 0; v < 4; v++)
      run_pass(tab[v].mode, tab[v].lat, tab[v].r0, tab[v].r1, tab[v].e0, tab[v].e1);

    for (int r = 0; r < 5; r++) begin
      r0 = 16'($urandom); r1 = 16'($urandom);
      run_pass(int'($urandom_range(0, 2)), int'($urandom_range(1, 4)), r0, r1, ref_relu(r0), ref_relu(r1));
    end

    // Abort while waiting on the second neuron's result.
    begin_pass(0, 12, 16'h3C00, 16'h4000);
    t = 0;
    while (hs_q.size() < 6 && t < 100) begin tick(1); t++; end
    tick(2);
    abort = 1'b1; tick(1); abort = 1'b0;
    chk("abort_idle", 32'({busy, mif.op_valid, wr_en, done}), 32'h0);
    tick(20);
    chk("abort_one_write", 32'(wr_q.size()), 32'h1);
    chk("abort_no_done", 32'(done_cnt), 32'h0);
    chk("abort_no_err", 32'(err), 32'h0);
    run_pass(0, 2, 16'h4200, 16'hC200, 16'h4200, 16'h0000);

    // Stray result strobe during ISSUE.
    begin_pass(3, 2, 16'h0, 16'h0);
    inject_rv = 1'b1; tick(1); inject_rv = 1'b0; tick(1);
    chk("stray_res_err", 32'(err), 32'h1);
    chk("stray_res_no_write", 32'(wr_q.size()), 32'h0);
    chk("stray_res_still_busy", 32'(busy), 32'h1);
    abort = 1'b1; tick(1); abort = 1'b0;
    chk("err_sticky_over_abort", 32'(err), 32'h1);
    run_pass(0, 1, 16'h3800, 16'h3400, 16'h3800, 16'h3400);

    // Asynchronous reset in the middle of a stalled ISSUE.
    begin_pass(1, 2, 16'h0, 16'h0);
    tick(3);
    rstn = 1'b0; #1;
    chk_reset_outs("reset_async");
    tick(2);
    chk_reset_outs("reset_held");
    rstn = 1'b1;
    tick(3);
    chk("no_resume_after_reset", 32'({busy, mif.op_valid}), 32'h0);
    run_pass(0, 2, 16'h3C00, 16'hBC00, 16'h3C00, 16'h0000);

    // Single-input layer, ReLU disabled.
    tick(1); start_b = 1'b1; tick(1); start_b = 1'b0;
    chk("b_first_last", 32'({mif_b.op_valid, mif_b.op_first, mif_b.op_last}), 32'h7);
    chk("b_addr_n0", 32'({mif_b.x_addr, mif_b.w_addr, mif_b.b_addr}), 32'h0);
    tick(1);
    chk("b_wait_no_valid", 32'(mif_b.op_valid), 32'h0);
    mif_b.res_valid = 1'b1; mif_b.res_data = 16'h8000; tick(1); mif_b.res_valid = 1'b0;
    chk("b_write0", 32'({wr_en_b, wr_addr_b, wr_data_b}), 32'({1'b1, 1'b0, 16'h8000}));
    tick(1);
    chk("b_n1_issue", 32'({mif_b.op_valid, mif_b.op_first, mif_b.op_last, mif_b.w_addr, mif_b.b_addr}), 32'h1F);
    tick(1);
    mif_b.res_valid = 1'b1; mif_b.res_data = 16'hC500; tick(1); mif_b.res_valid = 1'b0;
    chk("b_write1", 32'({wr_en_b, wr_addr_b, wr_data_b}), 32'({1'b1, 1'b1, 16'hC500}));
    tick(1);
    chk("b_done", 32'({done_b, busy_b, wr_en_b}), 32'h6);
    tick(1);
    chk("b_idle", 32'({done_b, busy_b, err_b}), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit, checks %0d/%0d", n_pass, n_tot);
    $fatal(1);
  end

endmodule

// File: doc/half_layer_sequencer.md
HALF_LAYER_SEQUENCER -- requirements
Module: half_layer_sequencer

Interface
REQ-001 SHALL have parameter N_IN, default 784, number of inputs per neuron (>=1).
REQ-002 SHALL have parameter N_OUT, default 50, number of neurons in the layer (>=1).
REQ-003 SHALL have parameter RELU_EN, default 1; 1 applies ReLU on writeback, 0 passes results through unchanged.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on the rising edge.
REQ-005 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  begin a layer pass; sampled only in IDLE.
REQ-007 SHALL have port abort  input  1  terminate the pass; no done.
REQ-008 SHALL have port busy  output  1  high in every state except IDLE.
REQ-009 SHALL have port done  output  1  one-cycle pulse after the final write.
REQ-010 SHALL have port op_valid  output  1  operand request to the shared half-precision MAC.
REQ-011 SHALL have port op_ready  input  1  MAC accepts the operand.
REQ-012 SHALL have port op_first  output  1  first term of a neuron; MAC seeds its accumulator from b[b_addr].
REQ-013 SHALL have port op_last  output  1  final term of a neuron.
REQ-014 SHALL have port x_addr  output  $clog2(N_IN)  input index i.
REQ-015 SHALL have port w_addr  output  $clog2(N_IN*N_OUT)  weight index i*N_OUT+j, row-major W[i][j].
REQ-016 SHALL have port b_addr  output  $clog2(N_OUT)  neuron index j.
REQ-017 SHALL have port res_valid  input  1  MAC result strobe.
REQ-018 SHALL have port res_data  input  16  IEEE half result.
REQ-019 SHALL have port wr_en, wr_addr ($clog2(N_OUT)), wr_data (16)  outputs  layer-output write port.
REQ-020 SHALL have port err  output  1  sticky protocol error.

Function
REQ-021 SHALL implement the FSM IDLE -> ISSUE -> WAIT -> WRITE -> (ISSUE | FIN) -> IDLE.
REQ-022 IDLE: start=1 -> ISSUE next cycle with i=0, j=0; op_valid rises one cycle after start.
REQ-023 ISSUE: op_valid=1; x_addr, w_addr, b_addr, op_first, op_last held stable until op_valid&op_ready.
REQ-024 On each handshake, i increments; op_first=(i==0); op_last=(i==N_IN-1); for N_IN=1 both are high together.
REQ-025 A handshake with op_last -> WAIT next cycle; op_valid=0 in WAIT.
REQ-026 WAIT: res_valid=1 -> WRITE next cycle; result registered; MAC latency unbounded.
REQ-027 WRITE: wr_en=1 for exactly one cycle; wr_addr=j; wr_data = 16'h0000 if RELU_EN and res_data[15]=1 (covers -0, negatives, negative NaN), else res_data.
REQ-028 After WRITE: j<N_OUT-1 -> j++, i=0, ISSUE; j==N_OUT-1 -> FIN.
REQ-029 FIN: done=1 for one cycle, busy=1; IDLE next cycle.
REQ-030 start while busy SHALL be ignored; start in the FIN cycle is ignored.
REQ-031 abort=1 in any non-IDLE state -> IDLE next cycle; op_valid, wr_en and done are 0 from that edge; abort has priority over every other event in the same cycle.
REQ-032 res_valid outside WAIT SHALL set err and be otherwise ignored; err clears only on reset or on an accepted start.
REQ-033 Counters SHALL never exceed N_IN-1 or N_OUT-1; no wrap-around beyond the terminal counts.
REQ-034 Zero-cycle gaps: with op_ready held at 1, one operand SHALL issue per cycle.

Reset
REQ-035 rstn low SHALL asynchronously force IDLE, i=j=0, busy=done=op_valid=op_first=op_last=wr_en=err=0, and all addresses and wr_data to 0.
REQ-036 Reset deasserted mid-pass SHALL NOT resume the pass; a new start is required.

Structure
REQ-037 Package half_nn_pkg SHALL hold typedef half_t (logic [15:0]), constant HALF_ZERO=16'h0000, the FSM state enum, and function half_relu.
REQ-038 One sub-module SHALL be used: half_seq_counter (parameterised terminal count, inc/clr/at_last), instantiated for i and j.
REQ-039 Address arithmetic SHALL use a running w_addr (+N_OUT per term, reset to j at neuron start); no multiplier.

Verification (N_IN=3, N_OUT=2, RELU_EN=1 unless noted)
REQ-040 start, op_ready=1, MAC latency 2, results 16'h3C00 and 16'hBC00 -> w_addr 0,2,4 then 1,3,5; writes (0,3C00),(1,0000); done 1 cycle after the 2nd write.
REQ-041 op_ready toggling 1/0 each cycle -> addresses and op_first/op_last stable across stalls; exactly 6 handshakes.
REQ-042 abort during the 2nd neuron's WAIT -> IDLE next cycle, no done; a subsequent start rewrites both neurons.
REQ-043 res_valid pulsed in ISSUE -> err=1, no write; err clears on the next start.
REQ-044 N_IN=1, RELU_EN=0, result 16'h8000 -> op_first and op_last high together; wr_data=8000.
REQ-045 rstn asserted mid-ISSUE, released, start again -> clean full pass, all outputs 0 while in reset.
